mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning cycles without s_ready before a forced completion (range 2..255).
REQ-002 SHALL have port clk, input, 1, the system clock; all state changes on the rising edge.
REQ-003 SHALL have port resetn, input, 1, synchronous, active-low reset.
REQ-004 SHALL have ports m0_valid/m0_instr (input, 1), m0_addr/m0_wdata (input, 32), m0_wstrb (input, 4), m0_ready (output, 1), m0_rdata (output, 32), forming master 0 (CPU) bus.
REQ-005 SHALL have the identical port set prefixed m1_, forming master 1 (test/DMA) bus.
REQ-006 SHALL have ports s_valid/s_instr (output, 1), s_addr/s_wdata (output, 32), s_wstrb (output, 4), s_ready (input, 1), s_rdata (input, 32), forming the shared peripheral bus.
REQ-007 SHALL have port grant, output, 2, one-hot owner of the shared bus (bit0 = m0, bit1 = m1, 00 = idle).
REQ-008 SHALL have port timeout_flag, output, 1, sticky indication that a forced completion occurred.

Function
REQ-009 SHALL implement a state machine with states IDLE, OWN_M0 and OWN_M1.
REQ-010 In IDLE, SHALL drive s_valid, s_instr, s_addr, s_wdata and s_wstrb to 0, and SHALL drive both m*_ready and m*_rdata to 0.
REQ-011 In IDLE with exactly one mX_valid high, SHALL enter OWN_MX on the next edge.
REQ-012 In IDLE with both valid high, SHALL grant the master not granted last; last_grant SHALL reset to m1 so m0 wins the first contention.
REQ-013 In OWN_MX, SHALL combinationally route mX_valid/instr/addr/wdata/wstrb to s_*, s_rdata to mX_rdata and s_ready to mX_ready; the other master SHALL see ready = 0 and rdata = 0.
REQ-014 In OWN_MX, the cycle s_ready is high, SHALL complete the transfer: return to IDLE on the next edge and set last_grant = X.
REQ-015 In OWN_MX, if mX_valid falls before s_ready, SHALL return to IDLE on the next edge without asserting mX_ready and without updating last_grant.
REQ-016 Grant latency SHALL be one cycle: s_valid is first asserted in the cycle after the request is seen in IDLE.
REQ-017 SHALL insert at least one IDLE cycle between consecutive grants, so no master is granted back-to-back while the other is requesting.
REQ-018 grant SHALL equal 01 in OWN_M0, 10 in OWN_M1 and 00 in IDLE, registered with the state.
REQ-019 s_ready asserted while in IDLE SHALL be ignored.

Reset
REQ-020 With resetn low at an edge, SHALL enter IDLE, set last_grant = m1, clear the timeout counter and timeout_flag, and force grant = 00.
REQ-021 A reset during OWN_MX SHALL abandon the transfer; s_valid SHALL be 0 from the first cycle after the reset edge.

Configuration
REQ-022 Macro BUS_TIMEOUT_EN SHALL control forced completion.
REQ-023 With BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to OWN_MX and increment each OWN_MX cycle without s_ready.
REQ-024 With BUS_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 and s_ready is low, the block SHALL assert mX_ready for one cycle with mX_rdata = 32'hDEADBEEF, set timeout_flag, and return to IDLE.
REQ-025 With BUS_TIMEOUT_EN defined, if s_ready and the timeout coincide, the block SHALL treat the cycle as a normal completion and leave timeout_flag unchanged.
REQ-026 Without BUS_TIMEOUT_EN, the counter SHALL be absent, timeout_flag SHALL be tied to 0, and a transfer SHALL wait indefinitely for s_ready.

Verification
REQ-027 Single master: m0 writes addr FFFF0060, wdata 5, wstrb 0001; slave readies on the 2nd grant cycle -> s_* mirror m0, grant = 01, m0_ready pulses once, then grant = 00.
REQ-028 Contention after reset: m0 and m1 both valid -> m0 served first, then m1 after one IDLE cycle; on repeated contention the masters alternate m0, m1, m0.
REQ-029 Read routing: m1 reads FFFF0040 with s_rdata = 32'h12345678 -> m1_rdata = 12345678 and m0_rdata = 0 in that cycle.
REQ-030 Abort: m0 drops valid in cycle 2 of OWN_M0 -> IDLE next cycle, no m0_ready, the next contention still grants m0.
REQ-031 Timeout (BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, slave never ready) -> m0_ready with rdata DEADBEEF in the 4th owned cycle, timeout_flag = 1 until reset.
REQ-032 Reset mid-transfer: resetn low in OWN_M1 -> next cycle grant = 00, s_valid = 0, and the next contention grants m0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave bus arbiter. When both masters request, the one not served last wins.
// Define BUS_TIMEOUT_EN to force completion of a transfer when the slave never becomes ready.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_flag
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StOwnM0 = 2'b01,
      StOwnM1 = 2'b10
   } state_e;

   localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

   state_e r_state;
   state_e w_state_d;
   logic   r_last_m1;
   logic   w_last_m1_d;
   logic   w_tmo_hit;
   logic   w_tmo_fire;

   // The state encoding is the one-hot grant, so grant is registered with the state.
   assign grant = r_state;

   always_comb begin
      w_state_d   = r_state;
      w_last_m1_d = r_last_m1;
      w_tmo_fire  = 1'b0;
      s_valid     = 1'b0;
      s_instr     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      m0_ready    = 1'b0;
      m0_rdata    = '0;
      m1_ready    = 1'b0;
      m1_rdata    = '0;
      unique case (r_state)
         StIdle: begin
            if (m0_valid && (!m1_valid || r_last_m1)) begin
               w_state_d = StOwnM0;
            end else if (m1_valid) begin
               w_state_d = StOwnM1;
            end
         end
         StOwnM0: begin
            s_valid  = m0_valid;
            s_instr  = m0_instr;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_rdata = s_rdata;
            if (!m0_valid) begin
               w_state_d = StIdle;
            end else if (s_ready) begin
               m0_ready    = 1'b1;
               w_state_d   = StIdle;
               w_last_m1_d = 1'b0;
            end else if (w_tmo_hit) begin
               m0_ready    = 1'b1;
               m0_rdata    = 32'hDEAD_BEEF;
               w_tmo_fire  = 1'b1;
               w_state_d   = StIdle;
               w_last_m1_d = 1'b0;
            end
         end
         StOwnM1: begin
            s_valid  = m1_valid;
            s_instr  = m1_instr;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_rdata = s_rdata;
            if (!m1_valid) begin
               w_state_d = StIdle;
            end else if (s_ready) begin
               m1_ready    = 1'b1;
               w_state_d   = StIdle;
               w_last_m1_d = 1'b1;
            end else if (w_tmo_hit) begin
               m1_ready    = 1'b1;
               m1_rdata    = 32'hDEAD_BEEF;
               w_tmo_fire  = 1'b1;
               w_state_d   = StIdle;
               w_last_m1_d = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= StIdle;
         r_last_m1 <= 1'b1;
      end else begin
         r_state   <= w_state_d;
         r_last_m1 <= w_last_m1_d;
      end
   end

`ifdef BUS_TIMEOUT_EN
   logic [7:0] r_tmo_cnt;
   logic       r_tmo_flag;

   // Held at zero while idle so every ownership starts counting from zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_tmo_cnt  <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         if (r_state == StIdle) begin
            r_tmo_cnt <= '0;
         end else if (!s_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         end
         if (w_tmo_fire) begin
            r_tmo_flag <= 1'b1;
         end
      end
   end

   assign w_tmo_hit    = (r_tmo_cnt == TmoLast);
   assign timeout_flag = r_tmo_flag;
`else
   logic w_unused_tmo;

   assign w_tmo_hit    = 1'b0;
   assign w_unused_tmo = ^{TmoLast, w_tmo_fire};
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle ownership model plus hand-computed spot checks.
module tb_mem_bus_arbiter;

   localparam int unsigned Tmo = 4;
`ifdef BUS_TIMEOUT_EN
   localparam bit TmoOn = 1'b1;
`else
   localparam bit TmoOn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        timeout_flag;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(Tmo)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who owns the bus (0 none, 1 m0, 2 m1), who was served last, how long we have owned.
   int m_owner = 0;
   bit m_last_m1 = 1'b1;
   bit m_flag = 1'b0;
   int m_owned = 0;

   always @(negedge clk) begin : p_model
      logic        v, rdy, fire;
      logic        e_instr;
      logic [31:0] e_addr, e_wdata, e_rd;
      logic [3:0]  e_wstrb;
      v = 1'b0; rdy = 1'b0; fire = 1'b0;
      e_instr = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
      if (m_owner == 1) begin
         v = m0_valid; e_instr = m0_instr; e_addr = m0_addr; e_wdata = m0_wdata;
         e_wstrb = m0_wstrb;
      end else if (m_owner == 2) begin
         v = m1_valid; e_instr = m1_instr; e_addr = m1_addr; e_wdata = m1_wdata;
         e_wstrb = m1_wstrb;
      end
      if (v && s_ready) begin
         rdy = 1'b1;
      end else if (v && TmoOn && m_owned == int'(Tmo)) begin
         rdy = 1'b1;
         fire = 1'b1;
      end
      e_rd = fire ? 32'hDEAD_BEEF : s_rdata;
      if (chk_en) begin
         chk("grant", 32'(grant), 32'(m_owner));
         chk("s_valid", 32'(s_valid), 32'(v));
         chk("s_instr", 32'(s_instr), 32'(e_instr));
         chk("s_addr", s_addr, e_addr);
         chk("s_wdata", s_wdata, e_wdata);
         chk("s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
         chk("m0_ready", 32'(m0_ready), (m_owner == 1) ? 32'(rdy) : 32'd0);
         chk("m0_rdata", m0_rdata, (m_owner == 1) ? e_rd : 32'd0);
         chk("m1_ready", 32'(m1_ready), (m_owner == 2) ? 32'(rdy) : 32'd0);
         chk("m1_rdata", m1_rdata, (m_owner == 2) ? e_rd : 32'd0);
         chk("timeout_flag", 32'(timeout_flag), 32'(m_flag));
      end
      if (!resetn) begin
         m_owner = 0; m_last_m1 = 1'b1; m_flag = 1'b0; m_owned = 0;
      end else if (m_owner == 0) begin
         if (m0_valid && m1_valid) m_owner = m_last_m1 ? 1 : 2;
         else if (m0_valid) m_owner = 1;
         else if (m1_valid) m_owner = 2;
         m_owned = (m_owner != 0) ? 1 : 0;
      end else if (!v) begin
         m_owner = 0;
      end else if (rdy) begin
         m_last_m1 = (m_owner == 2);
         m_flag = m_flag | fire;
         m_owner = 0;
      end else begin
         m_owned++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_ready = 0; s_rdata = '0;
   endtask

   initial begin
      int exp_g[6];
      bit seen;
      exp_g = '{0, 1, 0, 2, 0, 1};
      quiet();
      resetn = 1'b0;
      cyc(); cyc();
      chk_en = 1'b1;
      resetn = 1'b1;
      #3;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_flag", 32'(timeout_flag), 32'd0);

      // Single-master write, slave ready on the second owned cycle.
      m0_valid = 1; m0_instr = 0; m0_addr = 32'hFFFF_0060; m0_wdata = 32'd5; m0_wstrb = 4'b0001;
      #3;
      chk("t1_latency_grant", 32'(grant), 32'd0);
      chk("t1_latency_s_valid", 32'(s_valid), 32'd0);
      cyc(); #3;
      chk("t1_grant", 32'(grant), 32'd1);
      chk("t1_s_addr", s_addr, 32'hFFFF_0060);
      chk("t1_wait_ready", 32'(m0_ready), 32'd0);
      cyc(); s_ready = 1; #3;
      chk("t1_ready", 32'(m0_ready), 32'd1);
      chk("t1_s_wdata", s_wdata, 32'd5);
      chk("t1_s_wstrb", 32'(s_wstrb), 32'd1);
      cyc(); m0_valid = 0; s_ready = 0; #3;
      chk("t1_release", 32'(grant), 32'd0);

      // Contention straight after reset, slave always ready: m0, idle, m1, idle, m0.
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      m0_valid = 1; m0_addr = 32'hFFFF_0000;
      m1_valid = 1; m1_addr = 32'hFFFF_0004; m1_wdata = 32'hA5A5_0001; m1_wstrb = 4'hF;
      s_ready = 1;
      for (int i = 0; i < 6; i++) begin
         #3;
         chk("t2_grant_order", 32'(grant), 32'(exp_g[i]));
         cyc();
      end
      quiet();

      // Read routing to m1.
      cyc();
      m1_valid = 1; m1_addr = 32'hFFFF_0040;
      cyc();
      s_ready = 1; s_rdata = 32'h1234_5678; #3;
      chk("t3_m1_rdata", m1_rdata, 32'h1234_5678);
      chk("t3_m0_rdata", m0_rdata, 32'd0);
      chk("t3_m1_ready", 32'(m1_ready), 32'd1);
      chk("t3_grant", 32'(grant), 32'd2);
      cyc(); quiet();

      // Abort in the second owned cycle; last grant stays m1 so m0 wins next.
      m0_valid = 1; m0_addr = 32'hFFFF_0010;
      cyc(); #3;
      chk("t4_grant", 32'(grant), 32'd1);
      cyc(); m0_valid = 0; #3;
      chk("t4_abort_ready", 32'(m0_ready), 32'd0);
      chk("t4_abort_s_valid", 32'(s_valid), 32'd0);
      cyc(); #3;
      chk("t4_idle", 32'(grant), 32'd0);
      cyc(); m0_valid = 1; m1_valid = 1; s_ready = 1;
      cyc(); #3;
      chk("t4_m0_wins", 32'(grant), 32'd1);
      cyc(); quiet();

      // Slave never ready.
      m0_valid = 1; m0_instr = 1; m0_addr = 32'hFFFF_0020;
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         if (seen) m0_valid = 0;
         #3;
`ifdef BUS_TIMEOUT_EN
         if (i == 3) begin
            chk("t5_tmo_ready", 32'(m0_ready), 32'd1);
            chk("t5_tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
         end
`else
         if (i == 5) begin
            chk("t5_still_owned", 32'(grant), 32'd1);
            chk("t5_no_ready", 32'(m0_ready), 32'd0);
         end
`endif
         if (m0_ready) seen = 1'b1;
      end
      m0_valid = 0;
      cyc(); #3;
      chk("t5_idle", 32'(grant), 32'd0);
      chk("t5_flag", 32'(timeout_flag), 32'(TmoOn));
      quiet();

      // Reset during OWN_M1, then contention must go to m0.
      cyc();
      m1_valid = 1; m1_addr = 32'hFFFF_0080;
      cyc(); #3;
      chk("t6_grant", 32'(grant), 32'd2);
      cyc(); resetn = 1'b0;
      cyc();
      resetn = 1'b1; m0_valid = 1;
      #3;
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
      chk("t6_rst_flag", 32'(timeout_flag), 32'd0);
      cyc(); #3;
      chk("t6_m0_first", 32'(grant), 32'd1);
      cyc(); quiet();
      cyc(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
